expr_lane_pipe: RTL and testbench



---
 rtl/expr_pipe_pkg.sv | 33 +++
 rtl/expr_lane.sv | 57 +++++
 rtl/expr_lane_pipe.sv | 134 +++++++++++++
 tb/tb_expr_lane_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pipe_pkg.sv
// Shared opcode encoding, default geometry and lane-extraction helper for
// the expression lane pipeline.
package expr_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_LT  = 3'd6,
    OP_ACC = 3'd7
  } op_e;

  localparam int unsigned DEF_W      = 6;
  localparam int unsigned DEF_NLANES = 4;

  // Widest packed bus / lane the helper can extract from.
  localparam int unsigned LANE_BUS_W = 256;
  localparam int unsigned MAX_LANE_W = 32;

  function automatic logic [MAX_LANE_W-1:0] lane_slice(
    input logic [LANE_BUS_W-1:0] bus,
    input int unsigned           idx,
    input int unsigned           w
  );
    logic [LANE_BUS_W-1:0] mask;
    mask = (LANE_BUS_W'(1) << w) - LANE_BUS_W'(1);
    return MAX_LANE_W'((bus >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/expr_lane.sv
// Combinational single-lane ALU; signedness fixed at elaboration time.
module expr_lane
  import expr_pipe_pkg::*;
#(
  parameter int unsigned W      = DEF_W,
  parameter bit          SIGNED = 1'b0
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc,
  output logic [W-1:0] res,
  output logic         ovf
);

  logic [W-1:0] add_l;
  logic [W-1:0] add_r;
  logic [W:0]   sum_ext;
  logic [W:0]   diff_ext;
  logic         oversize;
  logic         lt;

  always_comb begin
    res      = '0;
    ovf      = 1'b0;
    // ACC shares the adder with ADD: acc + a instead of a + b.
    add_l    = (op == OP_ACC) ? acc : a;
    add_r    = (op == OP_ACC) ? a : b;
    sum_ext  = {1'b0, add_l} + {1'b0, add_r};
    diff_ext = {1'b0, a} - {1'b0, b};
    oversize = (32'(b) >= W);
    lt       = SIGNED ? ($signed(a) < $signed(b)) : (a < b);

    case (op)
      OP_ADD, OP_ACC: begin
        res = sum_ext[W-1:0];
        ovf = SIGNED ? ((add_l[W-1] == add_r[W-1]) && (sum_ext[W-1] != add_l[W-1]))
                     : sum_ext[W];
      end
      OP_SUB: begin
        res = diff_ext[W-1:0];
        ovf = SIGNED ? ((a[W-1] != b[W-1]) && (diff_ext[W-1] != a[W-1]))
                     : diff_ext[W];
      end
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      OP_SHL: res = oversize ? '0 : (a << b);
      OP_SHR: begin
        if (SIGNED) res = oversize ? {W{a[W-1]}} : W'($signed(a) >>> b);
        else        res = oversize ? '0 : (a >> b);
      end
      OP_LT:  res = {{(W-1){1'b0}}, lt};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/expr_lane_pipe.sv
// Two-stage valid/ready multi-lane expression evaluator with per-lane
// accumulators and sticky overflow flags.
module expr_lane_pipe
  import expr_pipe_pkg::*;
#(
  parameter int unsigned       NLANES      = DEF_NLANES,
  parameter int unsigned       W           = DEF_W,
  parameter logic [NLANES-1:0] SIGNED_MASK = 4'b1010
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [NLANES*W-1:0]   a,
  input  logic [NLANES*W-1:0]   b,
  input  logic                  clr_acc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NLANES*W-1:0]   y,
  output logic [NLANES-1:0]     ovf,
  output logic [NLANES-1:0]     sticky_ovf
);

  logic                s1_valid_q, s1_valid_d;
  op_e                 s1_op_q, s1_op_d;
  logic [NLANES*W-1:0] s1_a_q, s1_a_d;
  logic [NLANES*W-1:0] s1_b_q, s1_b_d;
  logic                out_valid_q, out_valid_d;
  logic [NLANES*W-1:0] y_q, y_d;
  logic [NLANES-1:0]   ovf_q, ovf_d;
  logic [NLANES-1:0]   sticky_q, sticky_d;
  logic [W-1:0]        acc_q [NLANES];
  logic [W-1:0]        acc_d [NLANES];

  logic [W-1:0]        lane_a   [NLANES];
  logic [W-1:0]        lane_b   [NLANES];
  logic [W-1:0]        lane_acc [NLANES];
  logic [W-1:0]        lane_res [NLANES];
  logic [NLANES-1:0]   lane_ovf;

  logic s2_adv, s1_adv, in_fire, s1_to_s2, acc_move;

  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_fire  = in_valid && s1_adv;
    s1_to_s2 = s1_valid_q && s2_adv;
    acc_move = s1_to_s2 && (s1_op_q == OP_ACC);
  end

  // Clear is folded into the ALU's accumulator operand so that a same-cycle
  // ACC transfer sees zero and the clear effectively happens first.
  always_comb begin
    for (int unsigned i = 0; i < NLANES; i++) begin
      lane_a[i]   = W'(lane_slice(LANE_BUS_W'(s1_a_q), i, W));
      lane_b[i]   = W'(lane_slice(LANE_BUS_W'(s1_b_q), i, W));
      lane_acc[i] = clr_acc ? '0 : acc_q[i];
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    expr_lane #(
      .W      (W),
      .SIGNED (SIGNED_MASK[g])
    ) u_lane (
      .op  (s1_op_q),
      .a   (lane_a[g]),
      .b   (lane_b[g]),
      .acc (lane_acc[g]),
      .res (lane_res[g]),
      .ovf (lane_ovf[g])
    );
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    sticky_d    = (sticky_q & ~{NLANES{clr_acc}}) | (s1_to_s2 ? lane_ovf : '0);

    if (s1_adv) s1_valid_d = in_valid;
    if (in_fire) begin
      s1_op_d = op_e'(op);
      s1_a_d  = a;
      s1_b_d  = b;
    end

    if (s2_adv) out_valid_d = s1_valid_q;
    if (s1_to_s2) begin
      for (int unsigned i = 0; i < NLANES; i++) y_d[i*W +: W] = lane_res[i];
      ovf_d = lane_ovf;
    end

    for (int unsigned i = 0; i < NLANES; i++) begin
      acc_d[i] = acc_move ? lane_res[i] : lane_acc[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= '0;
      sticky_q    <= '0;
      acc_q       <= '{default: '0};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = out_valid_q;
  assign y          = y_q;
  assign ovf        = ovf_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_expr_lane_pipe.sv
// Randomised and directed bench for expr_lane_pipe against an integer
// reference model of the lane operations and the two-slot handshake.
module tb_expr_lane_pipe;

  localparam int         NL = 4;
  localparam int         W  = 6;
  localparam int         BW = NL * W;
  localparam logic [3:0] SM = 4'b1010;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, clr_acc, out_valid, out_ready;
  logic [2:0]    op;
  logic [BW-1:0] a, b, y;
  logic [NL-1:0] ovf, sticky_ovf;

  expr_lane_pipe #(
    .NLANES      (NL),
    .W           (W),
    .SIGNED_MASK (SM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .clr_acc    (clr_acc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .ovf        (ovf),
    .sticky_ovf (sticky_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            op;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } beat_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: beat waiting in the first slot, the presented output,
  // per-lane accumulators and sticky flags.
  beat_t         s1_m[$];
  bit            m_ov;
  logic [BW-1:0] m_y;
  logic [NL-1:0] m_ovf, sticky_m;
  int            acc_m[NL];
  bit            armed = 1'b0;
  bit            last_fire, last_ofire;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {W'(l3), W'(l2), W'(l1), W'(l0)};
  endfunction

  function automatic void ref_eval(input int o, input int av, input int bv, input int accv,
                                   input bit sgn, output int res, output bit ov);
    int half, md, sa, sb, sacc, r;
    half = 1 << (W - 1);
    md   = 1 << W;
    sa   = (sgn && av >= half) ? av - md : av;
    sb   = (sgn && bv >= half) ? bv - md : bv;
    sacc = (sgn && accv >= half) ? accv - md : accv;
    r    = 0;
    ov   = 1'b0;
    case (o)
      0: begin r = sa + sb; ov = sgn ? (r < -half || r >= half) : (r >= md); end
      1: begin r = sa - sb; ov = sgn ? (r < -half || r >= half) : (r < 0); end
      2: r = av & bv;
      3: r = av ^ bv;
      4: r = (bv >= W) ? 0 : (av << bv);
      5: begin
        if (sgn) r = sa >>> ((bv >= W) ? W : bv);
        else     r = (bv >= W) ? 0 : (av >> bv);
      end
      6: r = (sa < sb) ? 1 : 0;
      default: begin r = sacc + sa; ov = sgn ? (r < -half || r >= half) : (r >= md); end
    endcase
    res = r & (md - 1);
  endfunction

  task automatic model_reset();
    s1_m.delete();
    m_ov     = 1'b0;
    m_y      = '0;
    m_ovf    = '0;
    sticky_m = '0;
    for (int i = 0; i < NL; i++) acc_m[i] = 0;
  endtask

  // One clock: drive at negedge, compare settled outputs, then advance the model
  // to reflect what the coming rising edge does.
  task automatic cycle(input bit rst, input bit vld, input int o, input logic [BW-1:0] av,
                       input logic [BW-1:0] bv, input bit clr, input bit ordy);
    bit    exp_rdy, s2adv, ov;
    beat_t bt;
    int    r;
    @(negedge clk);
    rst_n     = !rst;
    in_valid  = vld;
    op        = 3'(o);
    a         = av;
    b         = bv;
    clr_acc   = clr;
    out_ready = ordy;
    #1;
    exp_rdy = (s1_m.size() == 0) || !m_ov || ordy;
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("y", 32'(y), 32'(m_y));
        chk("ovf", 32'(ovf), 32'(m_ovf));
      end
      chk("sticky", 32'(sticky_ovf), 32'(sticky_m));
    end
    last_fire  = !rst && vld && exp_rdy;
    last_ofire = !rst && m_ov && ordy;
    if (rst) begin
      model_reset();
    end else begin
      s2adv = !m_ov || ordy;
      if (clr) begin
        for (int i = 0; i < NL; i++) acc_m[i] = 0;
        sticky_m = '0;
      end
      if (s2adv) begin
        if (s1_m.size() > 0) begin
          bt = s1_m.pop_front();
          for (int i = 0; i < NL; i++) begin
            ref_eval(bt.op, int'(bt.a[i*W +: W]), int'(bt.b[i*W +: W]), acc_m[i], SM[i], r, ov);
            m_y[i*W +: W] = W'(r);
            m_ovf[i]      = ov;
            if (bt.op == 7) acc_m[i] = r;
          end
          m_ov     = 1'b1;
          sticky_m = sticky_m | m_ovf;
        end else begin
          m_ov = 1'b0;
        end
      end
      if (last_fire) begin
        bt.op = o;
        bt.a  = av;
        bt.b  = bv;
        s1_m.push_back(bt);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic run1(input int o, input logic [BW-1:0] av, input logic [BW-1:0] bv);
    cycle(1'b0, 1'b1, o, av, bv, 1'b0, 1'b1);
    idle(2);
  endtask

  initial begin
    int k, nxt, idx;
    int exp_acc[4];
    bit exp_ov0[4];
    exp_acc = '{20, 40, 60, 16};
    exp_ov0 = '{1'b0, 1'b0, 1'b0, 1'b1};

    cycle(1'b1, 1'b0, 0, '0, '0, 1'b0, 1'b1);
    armed = 1'b1;
    cycle(1'b1, 1'b0, 0, '0, '0, 1'b0, 1'b1);
    idle(1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_sticky", 32'(sticky_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD wrap/overflow on lanes 0 and 1, two cycles of latency
    cycle(1'b0, 1'b1, 0, pack(63, 31, 10, 40), pack(1, 1, 5, 30), 1'b0, 1'b1);
    idle(1);
    chk("add_lat_early", 32'(out_valid), 32'd0);
    idle(1);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_y", 32'(y), 32'(pack(0, 32, 15, 6)));
    chk("add_ovf", 32'(ovf), 32'b0011);

    run1(5, pack(32, 32, 0, 0), pack(2, 2, 0, 0));
    chk("shr2_l0", 32'(y[0 +: W]), 32'd8);
    chk("shr2_l1", 32'(y[W +: W]), 32'd56);
    run1(5, pack(32, 32, 0, 0), pack(6, 6, 0, 0));
    chk("shr6_l0", 32'(y[0 +: W]), 32'd0);
    chk("shr6_l1", 32'(y[W +: W]), 32'd63);
    run1(4, pack(32, 32, 0, 0), pack(7, 7, 0, 0));
    chk("shl7", 32'(y[0 +: 2*W]), 32'd0);
    run1(6, pack(63, 63, 0, 0), pack(1, 1, 0, 0));
    chk("lt_l0", 32'(y[0 +: W]), 32'd0);
    chk("lt_l1", 32'(y[W +: W]), 32'd1);

    // Backpressure: only two beats fit while the output is stalled
    idle(3);
    k = 1;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b1, 0, pack(k, k, k, k), '0, 1'b0, 1'b0);
      if (last_fire) k++;
    end
    chk("bp_accepted", 32'(k - 1), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    nxt = 1;
    for (int c = 0; c < 30 && nxt <= 5; c++) begin
      cycle(1'b0, k <= 5, 0, pack(k, k, k, k), '0, 1'b0, 1'b1);
      if (last_ofire) begin
        chk("bp_seq", 32'(y[0 +: W]), 32'(nxt));
        nxt++;
      end
      if (last_fire) k++;
    end
    chk("bp_count", 32'(nxt), 32'd6);

    // Accumulator chain with wrap, then clear coinciding with an ACC transfer
    idle(3);
    cycle(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1);
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, c < 4, 7, pack(20, 0, 0, 0), '0, 1'b0, 1'b1);
      if (last_ofire && idx < 4) begin
        chk("acc_y", 32'(y[0 +: W]), 32'(exp_acc[idx]));
        chk("acc_ovf0", 32'(ovf[0]), 32'(exp_ov0[idx]));
        idx++;
      end
    end
    chk("acc_count", 32'(idx), 32'd4);
    chk("acc_sticky0", 32'(sticky_ovf[0]), 32'd1);
    cycle(1'b0, 1'b1, 7, pack(5, 0, 0, 0), '0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1);
    idle(1);
    chk("clr_acc_valid", 32'(out_valid), 32'd1);
    chk("clr_acc_y", 32'(y[0 +: W]), 32'd5);
    chk("clr_sticky0", 32'(sticky_ovf[0]), 32'd0);

    // Reset with both stages occupied
    idle(3);
    cycle(1'b0, 1'b1, 0, pack(9, 9, 9, 9), '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 0, pack(7, 7, 7, 7), '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    idle(1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_y", 32'(y), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    run1(7, pack(3, 0, 0, 0), '0);
    chk("mrst_acc_y", 32'(y[0 +: W]), 32'd3);

    for (int c = 0; c < 400; c++) begin
      cycle(1'b0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
            BW'($urandom), BW'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
